qos_wrr: RTL and testbench
==========================

// Module: qos_wrr
// PURPOSE
//  Parametrised next-generation QoS block: QUEUE_QUANTITY virtual-channel FIFOs with per-queue
//  hysteresis flow control (pausa/continuar) feeding one output via a 3-mode arbiter
//  (plain RR, weighted RR, table-driven). Replaces the fixed-size qos between the VC ingress and
//  the single output link; config is loaded on iniciar.
// PARAMETERS
//  QUEUE_QUANTITY  4   number of VC queues (>=2)
//  DATA_BITS       8   data word width
//  FIFO_DEPTH      16  entries per queue (power of 2)
//  MAX_WEIGHT      64  weight range; weight fields are $clog2(MAX_WEIGHT) bits
//  TABLE_SIZE      8   arbitration-table entries
// PORTS
//  clk                      in   1                 single clock, rising edge
//  rst                      in   1                 synchronous, active-high reset
//  enb                      in   1                 clock enable; low = all state frozen
//  iniciar                  in   1                 1-cycle pulse: latch config, enter ACTIVE
//  vc_id                    in   $clog2(Q)         target queue of a write
//  data_word                in   DATA_BITS         write data
//  wr_en / rd_en            in   1 / 1             push request / pop request
//  umbral_max / umbral_min  in   $clog2(DEPTH)+1   pause / resume occupancy thresholds
//  mem_seleccion_roundRobin in   2                 0 RR, 1 WRR, 2 table, 3 = RR
//  mem_pesos                in   Q*$clog2(MW)      per-queue WRR weights, queue 0 in LSBs
//  mem_pesosArbitraje       in   T*$clog2(MW)      per-table-entry grant counts
//  mem_selecciones          in   T*$clog2(Q)       per-table-entry queue id
//  error_full               out  Q                 sticky: write attempted to full queue
//  pausa                    out  Q                 occupancy >= umbral_max (hysteresis)
//  continuar                out  Q                 1-cycle pulse when pausa releases
//  idle                     out  1                 all queues empty
//  dataOut / valid_out      out  DATA_BITS / 1     popped word / qualifier
// BEHAVIOUR
//  - rst (sync, wins over all): FIFOs flushed, config regs 0, arbiter ptr/credit 0, state INIT;
//    outputs error_full=0 pausa=0 continuar=0 idle=1 dataOut=0 valid_out=0. Mid-op reset drops data.
//  - enb=0: no state/output register updates; continuar/valid_out hold their registered value.
//  - FSM INIT->ACTIVE on iniciar. In INIT wr_en/rd_en ignored. iniciar in ACTIVE reloads config,
//    zeroes arbiter ptr/credit, keeps FIFO contents.
//  - Write (ACTIVE, wr_en): queue vc_id full -> word dropped, error_full[vc_id]<=1 until rst;
//    else push. Push+pop same queue same cycle legal, count unchanged; pop only when not empty.
//  - Read (ACTIVE, rd_en, !idle): arbiter grants one non-empty queue, pops it; dataOut/valid_out
//    registered, latency 1 cycle. rd_en while idle -> valid_out=0, dataOut holds.
//  - Flow control, per queue, on post-update count c: !pausa & c>=umbral_max -> pausa<=1;
//    pausa & c<=umbral_min -> pausa<=0 and continuar<=1 for exactly one cycle. umbral_min>=umbral_max
//    is a config error; behaviour then = pause at max, release at max-1.
//  - Mode 0 RR: grant first non-empty queue after last granted (wrap Q-1 -> 0).
//  - Mode 1 WRR: stay on current queue for weight[q] grants (weight 0 treated as 1); move to next
//    non-empty queue (RR order) when credit exhausted or queue empties; credit reloads on move.
//  - Mode 2 table: entry k serves queue sel[k] for pesosArbitraje[k] grants (0 treated as 1), then
//    k<=(k+1) mod TABLE_SIZE. If sel[k] empty, same-cycle scan to next entry with non-empty queue.
//  - Counters: occupancy $clog2(DEPTH)+1 bits; credit $clog2(MW) bits; all ptrs wrap modulo size.
//  - idle combinational = AND of all queue-empty flags.
// STRUCTURE
//  - Shared header qos_defs.vh: mode codes QOS_RR=0, QOS_WRR=1, QOS_TABLE=2; FSM codes INIT/ACTIVE.
//  - Sub-module qos_fifo (one per queue, generate loop): sync FIFO, count, full/empty, push/pop.
//  - Top holds FSM, config regs, thresholds/hysteresis, arbiter, output register.
// TESTING
//  1 rst mid-stream with 5 words queued -> next cycle idle=1, pausa=0, valid_out=0, dataOut=0.
//  2 Mode0, one word in each of q0..q3, rd_en 4 cycles -> dataOut order q0,q1,q2,q3, 1-cycle latency.
//  3 Mode1 weights {1,3,0,2}, 6 words each, rd_en held -> grant pattern 0,1,1,1,2,3,3,0,...
//  4 Mode2 table sel{2,0,2,...} counts{2,1,...}, q0 empty -> q2,q2 then entry 1 skipped to q2.
//  5 umbral_max=12 umbral_min=4, push 12 to q1 -> pausa[1]=1; pop to 4 -> continuar[1] one pulse.
//  6 Fill q3 to 16, push 17th -> dropped, error_full[3]=1 sticky; enb=0 2 cycles -> all outputs hold.

Source files
------------

// File: rtl/qos_wrr_pkg.sv
// qos_wrr_pkg: arbitration mode and FSM encodings shared by the QoS block
package qos_wrr_pkg;
  typedef enum logic {INIT, ACTIVE} state_t;
  typedef enum logic [1:0] {QOS_RR = 2'd0, QOS_WRR = 2'd1, QOS_TABLE = 2'd2, QOS_RR3 = 2'd3} mode_t;
endpackage

// File: rtl/qos_wrr_fifo.sv
// qos_wrr_fifo: single-clock FIFO holding the words of one virtual channel
module qos_wrr_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enb,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DATA_BITS-1:0]          din,
  output logic [DATA_BITS-1:0]          dout,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          full,
  output logic                          empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == (AW + 1)'(FIFO_DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp];
  always_ff @(posedge clk) begin
    if (enb && do_push) mem[wp] <= din;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (enb) begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  end
endmodule

// File: rtl/qos_wrr.sv
// qos_wrr: per-VC FIFOs with hysteresis flow control feeding one output
// through a round-robin / weighted / table-driven arbiter.
module qos_wrr
  import qos_wrr_pkg::*;
#(
  parameter int QUEUE_QUANTITY = 4,
  parameter int DATA_BITS      = 8,
  parameter int FIFO_DEPTH     = 16,
  parameter int MAX_WEIGHT     = 64,
  parameter int TABLE_SIZE     = 8
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               enb,
  input  logic                                               iniciar,
  input  logic [$clog2(QUEUE_QUANTITY)-1:0]                  vc_id,
  input  logic [DATA_BITS-1:0]                               data_word,
  input  logic                                               wr_en,
  input  logic                                               rd_en,
  input  logic [$clog2(FIFO_DEPTH):0]                        umbral_max,
  input  logic [$clog2(FIFO_DEPTH):0]                        umbral_min,
  input  logic [1:0]                                         mem_seleccion_roundRobin,
  input  logic [QUEUE_QUANTITY*$clog2(MAX_WEIGHT)-1:0]       mem_pesos,
  input  logic [TABLE_SIZE*$clog2(MAX_WEIGHT)-1:0]           mem_pesosArbitraje,
  input  logic [TABLE_SIZE*$clog2(QUEUE_QUANTITY)-1:0]       mem_selecciones,
  output logic [QUEUE_QUANTITY-1:0]                          error_full,
  output logic [QUEUE_QUANTITY-1:0]                          pausa,
  output logic [QUEUE_QUANTITY-1:0]                          continuar,
  output logic                                               idle,
  output logic [DATA_BITS-1:0]                               dataOut,
  output logic                                               valid_out
);
  localparam int Q  = QUEUE_QUANTITY;
  localparam int QW = $clog2(Q);
  localparam int WW = $clog2(MAX_WEIGHT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int T  = TABLE_SIZE;
  localparam int TW = $clog2(T);
  state_t state;
  mode_t mode;
  logic [Q-1:0][WW-1:0] wgt;
  logic [T-1:0][WW-1:0] tcnt;
  logic [T-1:0][QW-1:0] tsel;
  logic [CW-1:0] umax, umin, umin_eff;
  logic [QW-1:0] ptr, ptr_inc, gnt;
  logic [TW-1:0] tidx, tnx;
  logic [TW:0] tpick;
  logic [WW-1:0] used, wq, tq;
  logic wstay, tstay, tok, act, wr, rd;
  logic [Q-1:0] empty, full, push, pop, werr;
  logic [Q-1:0][CW-1:0] count, cnt_nx;
  logic [Q-1:0][DATA_BITS-1:0] dout;
  for (genvar i = 0; i < Q; i++) begin : g_q
    qos_wrr_fifo #(.DATA_BITS(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .rst(rst), .enb(enb), .push(push[i]), .pop(pop[i]), .din(data_word),
      .dout(dout[i]), .count(count[i]), .full(full[i]), .empty(empty[i])
    );
    assign cnt_nx[i] = count[i] + CW'(push[i]) - CW'(pop[i]);
  end
  // first non-empty queue scanning upward from s, wrapping
  function automatic logic [QW-1:0] next_ne(input logic [Q-1:0] ne, input logic [QW-1:0] s);
    logic [QW-1:0] e;
    next_ne = s;
    for (int j = Q - 1; j >= 0; j--) begin
      e = QW'((int'(s) + j) % Q);
      if (ne[e]) next_ne = e;
    end
  endfunction
  // first table entry after k (k itself last) whose queue has data; MSB = found
  function automatic logic [TW:0] next_ent(input logic [Q-1:0] ne, input logic [T-1:0][QW-1:0] sel,
                                           input logic [TW-1:0] k);
    logic [TW-1:0] e;
    next_ent = '0;
    for (int j = T; j >= 1; j--) begin
      e = TW'((int'(k) + j) % T);
      if (ne[sel[e]]) next_ent = {1'b1, e};
    end
  endfunction
  assign act = state == ACTIVE;
  assign idle = &empty;
  assign umin_eff = umin >= umax ? umax - 1'b1 : umin;
  assign ptr_inc = ptr == QW'(Q - 1) ? '0 : ptr + 1'b1;
  assign wq = wgt[ptr] == '0 ? WW'(1) : wgt[ptr];
  assign tq = tcnt[tidx] == '0 ? WW'(1) : tcnt[tidx];
  assign wstay = !empty[ptr] && used < wq;
  assign tstay = !empty[tsel[tidx]] && used < tq;
  assign tpick = next_ent(~empty, tsel, tidx);
  assign tnx = tstay ? tidx : tpick[TW-1:0];
  assign tok = tstay || tpick[TW];
  assign gnt = mode == QOS_WRR ? (wstay ? ptr : next_ne(~empty, ptr_inc)) :
               mode == QOS_TABLE ? tsel[tnx] : next_ne(~empty, ptr);
  assign wr = enb && act && wr_en;
  // a table that maps to no non-empty queue cannot serve anything this cycle
  assign rd = enb && act && rd_en && !idle && (mode != QOS_TABLE || tok);
  assign push = (wr && !full[vc_id]) ? Q'(1) << vc_id : '0;
  assign werr = (wr && full[vc_id]) ? Q'(1) << vc_id : '0;
  assign pop = rd ? Q'(1) << gnt : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      mode <= QOS_RR;
      wgt <= '0;
      tcnt <= '0;
      tsel <= '0;
      umax <= '0;
      umin <= '0;
      ptr <= '0;
      tidx <= '0;
      used <= '0;
      error_full <= '0;
      pausa <= '0;
      continuar <= '0;
      dataOut <= '0;
      valid_out <= 1'b0;
    end else if (enb) begin
      valid_out <= rd;
      if (rd) dataOut <= dout[gnt];
      error_full <= error_full | werr;
      for (int i = 0; i < Q; i++) begin
        continuar[i] <= act && pausa[i] && cnt_nx[i] <= umin_eff;
        if (act && (pausa[i] ? cnt_nx[i] <= umin_eff : cnt_nx[i] >= umax)) pausa[i] <= !pausa[i];
      end
      if (iniciar) begin
        state <= ACTIVE;
        mode <= mode_t'(mem_seleccion_roundRobin);
        wgt <= mem_pesos;
        tcnt <= mem_pesosArbitraje;
        tsel <= mem_selecciones;
        umax <= umbral_max;
        umin <= umbral_min;
        ptr <= '0;
        tidx <= '0;
        used <= '0;
      end else if (rd) begin
        ptr <= mode == QOS_WRR ? gnt : (gnt == QW'(Q - 1) ? QW'(0) : gnt + 1'b1);
        used <= (mode == QOS_WRR ? wstay : tstay) ? used + 1'b1 : WW'(1);
        tidx <= tnx;
      end
    end
  end
endmodule

// File: tb/tb_qos_wrr.sv
// tb_qos_wrr: directed vectors plus randomized traffic against a queue-level reference model
module tb_qos_wrr;
  localparam int Q = 4, DB = 8, D = 16, MW = 64, T = 8, WW = 6, QW = 2, CW = 5;
  logic clk = 1'b0;
  logic rst, enb, iniciar, wr_en, rd_en;
  logic [QW-1:0] vc_id;
  logic [DB-1:0] data_word;
  logic [CW-1:0] umbral_max, umbral_min;
  logic [1:0] mem_seleccion_roundRobin;
  logic [Q*WW-1:0] mem_pesos;
  logic [T*WW-1:0] mem_pesosArbitraje;
  logic [T*QW-1:0] mem_selecciones;
  logic [Q-1:0] error_full, pausa, continuar;
  logic idle, valid_out;
  logic [DB-1:0] dataOut;
  qos_wrr #(.QUEUE_QUANTITY(Q), .DATA_BITS(DB), .FIFO_DEPTH(D), .MAX_WEIGHT(MW), .TABLE_SIZE(T)) dut (
    .clk(clk), .rst(rst), .enb(enb), .iniciar(iniciar), .vc_id(vc_id), .data_word(data_word),
    .wr_en(wr_en), .rd_en(rd_en), .umbral_max(umbral_max), .umbral_min(umbral_min),
    .mem_seleccion_roundRobin(mem_seleccion_roundRobin), .mem_pesos(mem_pesos),
    .mem_pesosArbitraje(mem_pesosArbitraje), .mem_selecciones(mem_selecciones),
    .error_full(error_full), .pausa(pausa), .continuar(continuar), .idle(idle),
    .dataOut(dataOut), .valid_out(valid_out)
  );
  always #5 clk = ~clk;
  int errors = 0, checks = 0;
  logic [7:0] mq[Q][$];
  bit m_act;
  int m_mode, m_max, m_min, m_cur, m_used, m_k;
  int m_w[Q];
  int m_tc[T];
  int m_ts[T];
  logic [Q-1:0] m_err, m_pa, m_co;
  logic m_val;
  logic [7:0] m_do;
  typedef struct {
    logic wr;
    logic [1:0] vc;
    logic [7:0] d;
    logic rd;
    logic ev;
    logic [7:0] ed;
  } vec_t;
  vec_t tv[9];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit model_idle();
    foreach (mq[i]) if (mq[i].size() != 0) return 0;
    return 1;
  endfunction

  function automatic int first_ne(input int s);
    for (int j = 0; j < Q; j++) if (mq[(s + j) % Q].size() > 0) return (s + j) % Q;
    return 0;
  endfunction

  // chooses the queue to serve under the latched mode and advances the arbiter's notion of position
  task automatic pick(output int g, output bit ok);
    int w, n, e;
    ok = 1;
    g = 0;
    if (m_mode == 1) begin
      w = m_w[m_cur] == 0 ? 1 : m_w[m_cur];
      if (mq[m_cur].size() > 0 && m_used < w) begin g = m_cur; m_used++; end
      else begin g = first_ne(m_cur + 1); m_cur = g; m_used = 1; end
    end else if (m_mode == 2) begin
      n = m_tc[m_k] == 0 ? 1 : m_tc[m_k];
      if (mq[m_ts[m_k]].size() > 0 && m_used < n) begin g = m_ts[m_k]; m_used++; end
      else begin
        ok = 0;
        for (int j = 1; j <= T; j++) begin
          e = (m_k + j) % T;
          if (!ok && mq[m_ts[e]].size() > 0) begin ok = 1; m_k = e; g = m_ts[e]; m_used = 1; end
        end
      end
    end else begin
      g = first_ne(m_cur);
      m_cur = (g + 1) % Q;
    end
  endtask

  task automatic model_tick();
    int g, me, c;
    bit rd, drop;
    if (rst) begin
      foreach (mq[i]) mq[i].delete();
      m_act = 0; m_mode = 0; m_max = 0; m_min = 0; m_cur = 0; m_used = 0; m_k = 0;
      foreach (m_w[i]) m_w[i] = 0;
      foreach (m_tc[k]) begin m_tc[k] = 0; m_ts[k] = 0; end
      m_err = '0; m_pa = '0; m_co = '0; m_val = 0; m_do = '0;
      return;
    end
    if (!enb) return;
    m_co = '0;
    rd = 0;
    g = 0;
    if (m_act && rd_en && !model_idle()) pick(g, rd);
    drop = m_act && wr_en && mq[vc_id].size() == D;
    m_val = rd;
    if (rd) m_do = mq[g].pop_front();
    if (m_act && wr_en) begin
      if (drop) m_err[vc_id] = 1'b1;
      else mq[vc_id].push_back(data_word);
    end
    if (m_act) begin
      me = (m_min >= m_max) ? m_max - 1 : m_min;
      for (int i = 0; i < Q; i++) begin
        c = mq[i].size();
        if (!m_pa[i] && c >= m_max) m_pa[i] = 1'b1;
        else if (m_pa[i] && c <= me) begin m_pa[i] = 1'b0; m_co[i] = 1'b1; end
      end
    end
    if (iniciar) begin
      m_act = 1;
      m_mode = mem_seleccion_roundRobin;
      m_max = umbral_max;
      m_min = umbral_min;
      for (int i = 0; i < Q; i++) m_w[i] = mem_pesos[i*WW +: WW];
      for (int k = 0; k < T; k++) begin
        m_tc[k] = mem_pesosArbitraje[k*WW +: WW];
        m_ts[k] = mem_selecciones[k*QW +: QW];
      end
      m_cur = 0; m_used = 0; m_k = 0;
    end
  endtask

  task automatic step();
    model_tick();
    @(posedge clk);
    #1;
    chk("idle", idle, model_idle());
    chk("pausa", pausa, m_pa);
    chk("continuar", continuar, m_co);
    chk("error_full", error_full, m_err);
    chk("valid_out", valid_out, m_val);
    chk("dataOut", dataOut, m_do);
  endtask

  task automatic do_reset();
    rst = 1; step(); rst = 0;
  endtask

  task automatic init(input logic [1:0] m, input logic [Q*WW-1:0] w, input logic [T*WW-1:0] tc,
                      input logic [T*QW-1:0] ts, input logic [CW-1:0] mx, input logic [CW-1:0] mn);
    mem_seleccion_roundRobin = m; mem_pesos = w; mem_pesosArbitraje = tc; mem_selecciones = ts;
    umbral_max = mx; umbral_min = mn;
    iniciar = 1; step(); iniciar = 0;
  endtask

  task automatic wr(input logic [QW-1:0] v, input logic [7:0] d);
    wr_en = 1; vc_id = v; data_word = d; step(); wr_en = 0;
  endtask

  task automatic rd();
    rd_en = 1; step(); rd_en = 0;
  endtask

  task automatic rand_init();
    logic [T*WW-1:0] tc;
    logic [Q*WW-1:0] w;
    for (int i = 0; i < Q; i++) w[i*WW +: WW] = WW'($urandom_range(0, 4));
    for (int k = 0; k < T; k++) tc[k*WW +: WW] = WW'($urandom_range(0, 3));
    init(2'($urandom_range(0, 3)), w, tc, (T*QW)'($urandom), CW'($urandom_range(1, 16)),
         CW'($urandom_range(0, 16)));
  endtask

  initial begin
    logic [T*QW-1:0] ts;
    logic [T*WW-1:0] tc;
    logic [7:0] first;
    int exp3[8];
    rst = 0; enb = 1; iniciar = 0; wr_en = 0; rd_en = 0; vc_id = '0; data_word = '0;
    umbral_max = 5'd16; umbral_min = '0; mem_seleccion_roundRobin = '0;
    mem_pesos = '0; mem_pesosArbitraje = '0; mem_selecciones = '0;
    tv[0] = '{1'b1, 2'd3, 8'hD3, 1'b0, 1'b0, 8'h00};
    tv[1] = '{1'b1, 2'd1, 8'hB1, 1'b0, 1'b0, 8'h00};
    tv[2] = '{1'b1, 2'd0, 8'hA0, 1'b0, 1'b0, 8'h00};
    tv[3] = '{1'b1, 2'd2, 8'hC2, 1'b0, 1'b0, 8'h00};
    tv[4] = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 8'hA0};
    tv[5] = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 8'hB1};
    tv[6] = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 8'hC2};
    tv[7] = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 8'hD3};
    tv[8] = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'hD3};
    // reset state
    do_reset();
    chk("rst_idle", idle, 1);
    chk("rst_valid", valid_out, 0);
    chk("rst_data", dataOut, 0);
    // writes ignored before iniciar
    wr(2'd1, 8'h55);
    chk("init_ignores_wr", idle, 1);
    // plain RR order and 1-cycle latency
    init(2'd0, '0, '0, '0, 5'd16, 5'd0);
    for (int i = 0; i < 9; i++) begin
      wr_en = tv[i].wr; vc_id = tv[i].vc; data_word = tv[i].d; rd_en = tv[i].rd;
      step();
      chk($sformatf("rr_vec%0d_valid", i), valid_out, tv[i].ev);
      chk($sformatf("rr_vec%0d_data", i), dataOut, tv[i].ed);
    end
    wr_en = 0; rd_en = 0;
    // WRR weights {1,3,0,2}
    do_reset();
    init(2'd1, {6'd2, 6'd0, 6'd3, 6'd1}, '0, '0, 5'd16, 5'd0);
    for (int n = 0; n < 6; n++) for (int q = 0; q < Q; q++) wr(QW'(q), {4'(q), 4'(n)});
    exp3 = '{0, 1, 1, 1, 2, 3, 3, 0};
    for (int i = 0; i < 8; i++) begin
      rd();
      chk($sformatf("wrr_grant%0d", i), dataOut[7:4], exp3[i]);
    end
    // table mode: q0 empty, entry 1 skipped, q1 never listed
    do_reset();
    for (int k = 0; k < T; k++) begin
      ts[k*QW +: QW] = (k == 1) ? 2'd0 : 2'd2;
      tc[k*WW +: WW] = (k == 0) ? 6'd2 : 6'd1;
    end
    init(2'd2, '0, tc, ts, 5'd16, 5'd0);
    for (int n = 0; n < 4; n++) wr(2'd2, 8'h20 + 8'(n));
    wr(2'd1, 8'h10);
    for (int n = 0; n < 4; n++) begin
      rd();
      chk($sformatf("tbl_data%0d", n), dataOut, 8'h20 + 8'(n));
    end
    rd();
    chk("tbl_unlisted_valid", valid_out, 0);
    chk("tbl_unlisted_hold", dataOut, 8'h23);
    // hysteresis on q1
    do_reset();
    init(2'd0, '0, '0, '0, 5'd12, 5'd4);
    for (int n = 0; n < 12; n++) begin
      wr(2'd1, 8'(n));
      chk($sformatf("hyst_fill%0d", n), pausa[1], n == 11);
    end
    for (int n = 0; n < 8; n++) begin
      rd();
      chk($sformatf("hyst_pop%0d_pausa", n), pausa[1], n < 7);
      chk($sformatf("hyst_pop%0d_cont", n), continuar[1], n == 7);
    end
    step();
    chk("hyst_cont_pulse_end", continuar[1], 0);
    // overflow on q3 and clock-enable hold
    do_reset();
    init(2'd0, '0, '0, '0, 5'd16, 5'd0);
    for (int n = 0; n < 16; n++) wr(2'd3, 8'h40 + 8'(n));
    chk("ovf_before", error_full, 0);
    wr(2'd3, 8'hEE);
    chk("ovf_sticky", error_full, 4'b1000);
    rd();
    first = dataOut;
    chk("ovf_first", first, 8'h40);
    enb = 0; rd_en = 1; wr_en = 1; vc_id = 2'd0; iniciar = 1;
    for (int n = 0; n < 2; n++) begin
      step();
      chk("enb_hold_valid", valid_out, 1);
      chk("enb_hold_data", dataOut, first);
    end
    enb = 1; rd_en = 0; wr_en = 0; iniciar = 0;
    for (int n = 1; n < 16; n++) rd();
    chk("ovf_last_kept", dataOut, 8'h4F);
    rd();
    chk("ovf_drained", valid_out, 0);
    chk("ovf_still_sticky", error_full, 4'b1000);
    // mid-stream reset with 5 queued words
    do_reset();
    init(2'd0, '0, '0, '0, 5'd3, 5'd1);
    for (int n = 0; n < 5; n++) wr(2'd0, 8'h61 + 8'(n));
    rd();
    rst = 1; step(); rst = 0;
    chk("midrst_idle", idle, 1);
    chk("midrst_pausa", pausa, 0);
    chk("midrst_valid", valid_out, 0);
    chk("midrst_data", dataOut, 0);
    // randomized traffic
    for (int ep = 0; ep < 8; ep++) begin
      int wp;
      do_reset();
      rand_init();
      wp = $urandom_range(30, 80);
      for (int c = 0; c < 300; c++) begin
        rst = $urandom_range(0, 299) == 0;
        enb = $urandom_range(0, 9) != 0;
        wr_en = $urandom_range(0, 99) < wp;
        rd_en = $urandom_range(0, 99) < 55;
        vc_id = QW'($urandom);
        data_word = 8'($urandom);
        if ($urandom_range(0, 79) == 0) rand_init();
        else step();
      end
      rst = 0; enb = 1; wr_en = 0; rd_en = 0;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
